// File: rtl/dsp_pkg.sv
// Shared widths and Z-operand select encodings for the DSP48A1-style
// multiply / post-add datapath.
package dsp_pkg;

    localparam int W_IN = 18;
    localparam int W_M  = 36;
    localparam int W_P  = 48;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PFB  = 2'b01;
    localparam logic [1:0] Z_C    = 2'b10;

endpackage

// File: rtl/mult_post_accum_stage_if.sv
// Operand, control and result bundle between the pre-adder side and the
// multiply / post-add stage.
interface mult_post_accum_stage_if;
    import dsp_pkg::*;

    logic            in_valid;
    logic [W_IN-1:0] pre_out;
    logic [W_IN-1:0] A1;
    logic [W_P-1:0]  C;
    logic [1:0]      opmode_z;
    logic            post_sub;
    logic            carry_in;
    logic [W_M-1:0]  M;
    logic [W_P-1:0]  P;
    logic            CARRYOUT;
    logic            out_valid;

    modport master (
        output in_valid, pre_out, A1, C, opmode_z, post_sub, carry_in,
        input  M, P, CARRYOUT, out_valid
    );

    modport slave (
        input  in_valid, pre_out, A1, C, opmode_z, post_sub, carry_in,
        output M, P, CARRYOUT, out_valid
    );

endinterface

// File: rtl/mult_post_accum_stage_pipe_reg_mux.sv
// Optional pipeline register: CE-gated, async active-high reset, bypassed
// when REG is 0.
module pipe_reg_mux #(
    parameter int W   = 1,
    parameter int REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else if (ce) begin
            r <= d;
        end
    end

    // REG is constant, so the unused path folds away in synthesis.
    assign q = (REG != 0) ? r : d;

endmodule

// File: rtl/mult_post_accum_stage.sv
// Multiplier plus 48-bit post-adder/subtracter with optional M and P
// registers, P-feedback accumulate and a matching valid pipeline.
module mult_post_accum_stage
    import dsp_pkg::*;
#(
    parameter int MREG          = 1,
    parameter int PREG          = 1,
    parameter int RSTTYPE_ASYNC = 1
) (
    input logic                    CLK,
    input logic                    RST,
    input logic                    CEM,
    input logic                    CEP,
    mult_post_accum_stage_if.slave bus
);

    if (RSTTYPE_ASYNC != 1) begin : g_bad_rsttype
        $error("mult_post_accum_stage: only asynchronous reset is supported");
    end

    logic [W_M-1:0] product;
    logic [W_M-1:0] m_q;
    logic           m_valid;
    logic [W_P-1:0] z_pfb;
    logic [W_P-1:0] z;
    logic [W_P:0]   z_ext;
    logic [W_P:0]   m_ext;
    logic [W_P:0]   cin_ext;
    logic [W_P:0]   sum;

    assign product = {{(W_M-W_IN){1'b0}}, bus.pre_out} * {{(W_M-W_IN){1'b0}}, bus.A1};

    pipe_reg_mux #(.W(W_M), .REG(MREG)) u_m_data (
        .clk(CLK), .rst(RST), .ce(CEM), .d(product), .q(m_q)
    );

    pipe_reg_mux #(.W(1), .REG(MREG)) u_m_valid (
        .clk(CLK), .rst(RST), .ce(CEM), .d(bus.in_valid), .q(m_valid)
    );

    assign bus.M = m_q;

    // Without a P register, feedback would form a combinational loop.
    if (PREG != 0) begin : g_pfb
        assign z_pfb = bus.P;
    end else begin : g_no_pfb
        assign z_pfb = '0;
    end

    always_comb begin
        z = '0;
        case (bus.opmode_z)
            Z_PFB:   z = z_pfb;
            Z_C:     z = bus.C;
            default: z = '0;
        endcase
    end

    assign z_ext   = {1'b0, z};
    assign m_ext   = {{(W_P-W_M+1){1'b0}}, m_q};
    assign cin_ext = {{W_P{1'b0}}, bus.carry_in};

    // Bit 48 is the carry on add and the borrow on subtract.
    assign sum = bus.post_sub ? (z_ext - (m_ext + cin_ext))
                              : (z_ext + m_ext + cin_ext);

    pipe_reg_mux #(.W(W_P), .REG(PREG)) u_p_data (
        .clk(CLK), .rst(RST), .ce(CEP), .d(sum[W_P-1:0]), .q(bus.P)
    );

    pipe_reg_mux #(.W(1), .REG(PREG)) u_carry (
        .clk(CLK), .rst(RST), .ce(CEP), .d(sum[W_P]), .q(bus.CARRYOUT)
    );

    pipe_reg_mux #(.W(1), .REG(PREG)) u_p_valid (
        .clk(CLK), .rst(RST), .ce(CEP), .d(m_valid), .q(bus.out_valid)
    );

endmodule

// File: doc/mult_post_accum_stage.md
Name: mult_post_accum_stage

Overview:
- Stage directly downstream of the 18-bit pre-adder/subtracter in the DSP48A1 slice datapath.
- Multiplies the pre-adder result by the A1 operand and optionally registers the product (M register).
- A 48-bit post-adder/subtracter then combines the product with a selectable Z operand (zero, P feedback, or C port) plus a carry-in, and optionally registers the sum (P register).
- Provides multiply-accumulate and a valid pipeline that tracks the configured latency.

Parameters:
MREG, 1, 1 = product registered in M register; 0 = product combinational.
PREG, 1, 1 = post-adder output registered in P register; 0 = combinational.
RSTTYPE_ASYNC, 1, fixed at 1 (documents the asynchronous reset); any other value is a synthesis-time error.

Ports:
CLK  input  1  single clock, rising edge.
RST  input  1  asynchronous active-high reset; clears M, P, CARRYOUT, and the valid pipeline.
CEM  input  1  clock enable for the M register stage and its valid bit.
CEP  input  1  clock enable for the P register, CARRYOUT register, and P valid bit.
in_valid  input  1  marks that pre_out/A1 carry a new operand pair.
pre_out  input  18  unsigned result from the pre-adder.
A1  input  18  unsigned multiplier operand.
C  input  48  external Z operand.
opmode_z  input  2  Z select: 00 = zero, 01 = P feedback, 10 = C, 11 = zero.
post_sub  input  1  0 = Z + (M + cin); 1 = Z - (M + cin).
carry_in  input  1  post-adder carry-in.
M  output  36  product (registered if MREG = 1).
P  output  48  post-adder result.
CARRYOUT  output  1  bit 48 of the 49-bit post-adder result.
out_valid  output  1  P/CARRYOUT hold the result of a valid input.

Behaviour:
- Reset values: M = 0, P = 0, CARRYOUT = 0, and all valid bits = 0, asserted immediately on RST rising (asynchronous).
- RST has priority over CEM/CEP.
- Deasserting RST mid-accumulation restarts accumulation from P = 0.
- Product: M = pre_out * A1, unsigned, full 36-bit result with no truncation.
- The product is zero-extended to 48 bits before the post-adder.
- Post-adder width rules: computed at 49 bits.
  - post_sub = 0: R = {1'b0, Z} + {13'b0, M} + carry_in.
  - post_sub = 1: R = {1'b0, Z} - ({13'b0, M} + carry_in).
  - P = R[47:0], wrapping mod 2^48.
  - CARRYOUT = R[48]: carry on add; borrow (1 when Z < M + cin) on subtract.
- opmode_z = 01 selects the current P register value.
  - If PREG = 0, 01 is treated as zero; a combinational loop is forbidden.
  - opmode_z = 11 is reserved and behaves as zero.
- opmode_z, post_sub, and carry_in are sampled in the same cycle as the operand at the post-adder input.
  - With MREG = 1, this is one cycle after pre_out/A1.
  - These controls are not pipelined by this block; upstream aligns them.
- Latency from pre_out/A1 to P equals MREG + PREG cycles (0, 1, or 2).
  - out_valid is in_valid delayed through the same stages.
  - Each valid bit advances only when its stage CE is high.
- CE low:
  - CEM = 0 holds M and the M valid bit.
  - CEP = 0 holds P, CARRYOUT, and out_valid, including during accumulate, so no accumulation occurs.
- Accumulate uses P feedback every enabled cycle regardless of in_valid. The caller gates accumulation through CEP or by feeding operands of zero.
- M output always reflects the M stage (registered or combinational), independent of PREG.

Decomposition:
- Shared package dsp_pkg:
  - widths: W_IN = 18, W_M = 36, W_P = 48.
  - Z select constants: Z_ZERO = 2'b00, Z_PFB = 2'b01, Z_C = 2'b10.
- One sub-module: pipe_reg_mux, a parameterised-width register with CE and async active-high reset plus a bypass mux selected by a REG parameter.
  - Instantiated for the M data, P data, CARRYOUT, and each valid bit.

Test Plan:
- Reset: RST = 1 mid-stream with P = 0x123 → P, M, CARRYOUT, and out_valid all 0 before the next CLK edge; they stay 0 until RST = 0.
- Multiply/latency (MREG = 1, PREG = 1): pre_out = 0x3FFFF, A1 = 0x3FFFF, opmode_z = 00, post_sub = 0, cin = 0, in_valid pulse → M = 0xFFFF80001 after 1 cycle; P = 0x0000FFFF80001 and out_valid = 1 after 2 cycles.
- Accumulate: pre_out = 5, A1 = 3, opmode_z = 01, CEP held high for 4 cycles from P = 0 → P sequence 15, 30, 45, 60; CEP = 0 for 2 cycles holds P = 60.
- Carry/wrap: opmode_z = 10, C = 0xFFFFFFFFFFFF, M = 1, cin = 0, add → P = 0, CARRYOUT = 1; same with cin = 1 → P = 1, CARRYOUT = 1.
- Subtract/borrow: C = 10, M = 4, cin = 1, post_sub = 1 → P = 5, CARRYOUT = 0; C = 3, M = 4, cin = 0 → P = 0xFFFFFFFFFFFF, CARRYOUT = 1.
- Bypass (MREG = 0, PREG = 0): combinational P equals C + pre_out*A1 in the same cycle; opmode_z = 01 yields Z = 0; out_valid equals in_valid.
